// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the M-extension sequencing controller:
//   - funct3 codes of the supported multiply/divide operations
//   - controller state encoding
//   - helper deciding whether a funct3 code is handled by this block
package muldiv_pkg;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [2:0] {
    OP_MUL  = F3_MUL,
    OP_DIV  = F3_DIV,
    OP_DIVU = F3_DIVU,
    OP_REM  = F3_REM,
    OP_REMU = F3_REMU
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_WAIT = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_DONE     = 3'd3,
    S_DRAIN    = 3'd4
  } state_e;

  // MULH* variants (001/010/011) are not handled here and report an error.
  function automatic logic is_supported(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_MUL, F3_DIV, F3_DIVU, F3_REM, F3_REMU: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
// Bundles every non-clock signal of the controller.
//   Request side : req_valid, req_op, req_word, req_a, req_b, kill, stall_o
//   Response side: resp_valid, resp_ready, resp_data, resp_err
//   Multiplier   : mul_valid, mul_ok, mul_out
//   Divider      : div_valid, div_signed, div_word, div_ok, div_q, div_r
// Modports:
//   slave  - the controller itself
//   master - its environment (EX stage, downstream stage, iterative units)
interface muldiv_ctrl_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic [2:0]      req_op;
  logic            req_word;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            kill;
  logic            stall_o;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;
  logic            mul_valid;
  logic            mul_ok;
  logic [XLEN-1:0] mul_out;
  logic            div_valid;
  logic            div_signed;
  logic            div_word;
  logic            div_ok;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] div_r;

  modport slave (
    input  req_valid, req_op, req_word, req_a, req_b, kill, resp_ready,
    input  mul_ok, mul_out, div_ok, div_q, div_r,
    output stall_o, resp_valid, resp_data, resp_err,
    output mul_valid, div_valid, div_signed, div_word
  );

  modport master (
    output req_valid, req_op, req_word, req_a, req_b, kill, resp_ready,
    output mul_ok, mul_out, div_ok, div_q, div_r,
    input  stall_o, resp_valid, resp_data, resp_err,
    input  mul_valid, div_valid, div_signed, div_word
  );
endinterface

// File: rtl/muldiv_fastpath.sv
// muldiv_fastpath
// Combinational detection of the RISC-V divide special cases that never
// need the iterative divider.
//   a_i, b_i  : dividend / divisor
//   word_i    : 32-bit variant, only the low words are inspected
//   signed_i  : signed divide (overflow case only exists for signed ops)
//   hit_o     : a special case applies
//   q_o, r_o  : architectural quotient / remainder for that case
//               (unformatted; the caller sign-extends word results)
module muldiv_fastpath #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            word_i,
  input  logic            signed_i,
  output logic            hit_o,
  output logic [XLEN-1:0] q_o,
  output logic [XLEN-1:0] r_o
);

  logic zero_s;
  logic ovf_s;

  // Special-case detection and the matching quotient/remainder
  always_comb begin
    zero_s = 1'b0;
    ovf_s  = 1'b0;
    q_o    = {XLEN{1'b0}};
    r_o    = {XLEN{1'b0}};
    if (word_i) begin
      zero_s = (b_i[31:0] == 32'h0000_0000);
      ovf_s  = signed_i && (a_i[31:0] == 32'h8000_0000) && (b_i[31:0] == 32'hFFFF_FFFF);
    end else begin
      zero_s = (b_i == {XLEN{1'b0}});
      ovf_s  = signed_i && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}});
    end
    if (zero_s) begin
      q_o = {XLEN{1'b1}};
      r_o = a_i;
    end else if (ovf_s) begin
      q_o = a_i;
      r_o = {XLEN{1'b0}};
    end else begin
      q_o = {XLEN{1'b0}};
      r_o = {XLEN{1'b0}};
    end
  end

  assign hit_o = zero_s | ovf_s;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Sequencing controller for the shared iterative multiplier/divider of the
// EX-stage ALU. Accepts one M-extension op at a time, resolves divide
// special cases locally, launches the right unit otherwise, formats the
// result, stalls EX while busy and handles kills and unit timeouts.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : muldiv_ctrl_if.slave (request, response and unit handshakes)
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = 127,
  parameter int XLEN    = 64
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  // The wait cycle in which the counter holds TIMEOUT-1 is the TIMEOUT-th one.
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;

  logic            fp_hit_s;
  logic [XLEN-1:0] fp_q_s;
  logic [XLEN-1:0] fp_r_s;
  logic            timeout_s;
  logic            drain_ok_s;

  // Word results are the low 32 bits sign-extended to XLEN.
  function automatic logic [XLEN-1:0] fmt(input logic word, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] res;
    if (word) begin
      res = {{(XLEN-32){v[31]}}, v[31:0]};
    end else begin
      res = v;
    end
    return res;
  endfunction

  muldiv_fastpath #(.XLEN(XLEN)) u_fastpath (
    .a_i      (bus.req_a),
    .b_i      (bus.req_b),
    .word_i   (bus.req_word),
    .signed_i (~bus.req_op[0]),
    .hit_o    (fp_hit_s),
    .q_o      (fp_q_s),
    .r_o      (fp_r_s)
  );

  assign timeout_s  = (cnt_q == CNT_LAST);
  // While draining, only the unit that was launched can complete the op.
  assign drain_ok_s = (op_q == F3_MUL) ? bus.mul_ok : bus.div_ok;

  // State, counter and latched op/result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= F3_MUL;
      word_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.kill) begin
          op_d   = bus.req_op;
          word_d = bus.req_word;
          cnt_d  = {CW{1'b0}};
          err_d  = 1'b0;
          if (!is_supported(bus.req_op)) begin
            state_d  = S_DONE;
            result_d = {XLEN{1'b0}};
            err_d    = 1'b1;
          end else if (bus.req_op == F3_MUL) begin
            state_d = S_MUL_WAIT;
          end else if (fp_hit_s) begin
            // req_op[1] distinguishes REM* from DIV*
            state_d  = S_DONE;
            result_d = fmt(bus.req_word, bus.req_op[1] ? fp_r_s : fp_q_s);
          end else begin
            state_d = S_DIV_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_WAIT, S_DIV_WAIT: begin
        if ((state_q == S_MUL_WAIT) ? bus.mul_ok : bus.div_ok) begin
          if (bus.kill) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DONE;
            err_d    = 1'b0;
            if (state_q == S_MUL_WAIT) begin
              result_d = fmt(word_q, bus.mul_out);
            end else begin
              result_d = fmt(word_q, op_q[1] ? bus.div_r : bus.div_q);
            end
          end
        end else if (timeout_s) begin
          if (bus.kill) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DONE;
            result_d = {XLEN{1'b0}};
            err_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = bus.kill ? S_DRAIN : state_q;
        end
      end
      S_DRAIN: begin
        if (drain_ok_s || timeout_s) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (bus.kill || bus.resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    bus.mul_valid  = 1'b0;
    bus.div_valid  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.stall_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.stall_o = bus.req_valid & ~bus.kill;
      end
      S_MUL_WAIT: begin
        bus.mul_valid = 1'b1;
        bus.stall_o   = 1'b1;
      end
      S_DIV_WAIT: begin
        bus.div_valid = 1'b1;
        bus.stall_o   = 1'b1;
      end
      S_DONE: begin
        bus.resp_valid = 1'b1;
        bus.stall_o    = ~bus.resp_ready;
      end
      S_DRAIN: begin
        // The killed op no longer blocks EX, but a fresh request must wait.
        bus.mul_valid = (op_q == F3_MUL);
        bus.div_valid = (op_q != F3_MUL);
        bus.stall_o   = bus.req_valid;
      end
      default: begin
        bus.stall_o = 1'b0;
      end
    endcase
  end

  assign bus.resp_data  = result_q;
  assign bus.resp_err   = err_q & (state_q == S_DONE);
  // Qualified by div_valid so the divider controls read 0 while idle.
  assign bus.div_signed = bus.div_valid & ~op_q[0];
  assign bus.div_word   = bus.div_valid & word_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl_if #(.XLEN(64)) bus();

  muldiv_ctrl #(.TIMEOUT(8), .XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } fp_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'b000;
    bus.req_word   = 1'b0;
    bus.req_a      = 64'd0;
    bus.req_b      = 64'd0;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;
    bus.mul_ok     = 1'b0;
    bus.mul_out    = 64'd0;
    bus.div_ok     = 1'b0;
    bus.div_q      = 64'd0;
    bus.div_r      = 64'd0;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_word  = word;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  task automatic test_reset();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL reset_mul_valid: got %b expected 0", bus.mul_valid); end
    checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL reset_div_valid: got %b expected 0", bus.div_valid); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
    checks++; if (bus.resp_data !== 64'd0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
  endtask

  task automatic test_mul();
    drive_req(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL mul_stall_accept: got %b expected 1", bus.stall_o); end
    checks++; if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL mul_valid_idle: got %b expected 0", bus.mul_valid); end
    tick();
    checks++; if (bus.mul_valid !== 1'b1) begin errors++; $display("FAIL mul_valid_wait1: got %b expected 1", bus.mul_valid); end
    checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL mul_no_div: got %b expected 0", bus.div_valid); end
    tick();
    bus.mul_ok  = 1'b1;
    bus.mul_out = 64'hFFFF_FFFF_FFFF_FFEB;
    #1;
    checks++; if (bus.mul_valid !== 1'b1) begin errors++; $display("FAIL mul_valid_ok_cycle: got %b expected 1", bus.mul_valid); end
    tick();
    bus.mul_ok  = 1'b0;
    bus.mul_out = 64'd0;
    #1;
    checks++; if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL mul_valid_done: got %b expected 0", bus.mul_valid); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL mul_err: got %b expected 0", bus.resp_err); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL mul_resp_valid_hold%0d: got %b expected 1", k, bus.resp_valid); end
      checks++; if (bus.resp_data !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_data_hold%0d: got %h expected ffffffffffffffeb", k, bus.resp_data); end
      checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL mul_stall_hold%0d: got %b expected 1", k, bus.stall_o); end
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL mul_stall_release: got %b expected 0", bus.stall_o); end
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mul_back_idle: got %b expected 0", bus.resp_valid); end
  endtask

  task automatic test_fastpath();
    fp_vec_t tab[7];
    tab[0] = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
    tab[1] = '{3'b111, 1'b0, 64'd100, 64'd0, 64'd100};
    tab[2] = '{3'b101, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tab[3] = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    tab[4] = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    tab[5] = '{3'b100, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    tab[6] = '{3'b110, 1'b1, 64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0005};
    for (int i = 0; i < 7; i++) begin
      drive_req(tab[i].op, tab[i].word, tab[i].a, tab[i].b);
      #1;
      checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL fp%0d_stall: got %b expected 1", i, bus.stall_o); end
      tick();
      bus.req_valid = 1'b0;
      #1;
      checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL fp%0d_div_valid: got %b expected 0", i, bus.div_valid); end
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL fp%0d_resp_valid: got %b expected 1", i, bus.resp_valid); end
      checks++; if (bus.resp_data !== tab[i].exp) begin errors++; $display("FAIL fp%0d_data: got %h expected %h", i, bus.resp_data, tab[i].exp); end
      bus.resp_ready = 1'b1;
      #1;
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL fp%0d_stall_release: got %b expected 0", i, bus.stall_o); end
      tick();
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic test_unsupported();
    drive_req(3'b001, 1'b0, 64'd3, 64'd4);
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.resp_err !== 1'b1) begin errors++; $display("FAIL unsup_err: got %b expected 1", bus.resp_err); end
    checks++; if (bus.resp_data !== 64'd0) begin errors++; $display("FAIL unsup_data: got %h expected 0", bus.resp_data); end
    checks++; if ((bus.mul_valid | bus.div_valid) !== 1'b0) begin errors++; $display("FAIL unsup_unit_valid: got %b expected 0", bus.mul_valid | bus.div_valid); end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    drive_req(3'b000, 1'b0, 64'd1, 64'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.mul_valid !== 1'b1) begin errors++; $display("FAIL tmo_mul_valid_wait%0d: got %b expected 1", i + 1, bus.mul_valid); end
      tick();
    end
    checks++; if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL tmo_mul_valid_drop: got %b expected 0", bus.mul_valid); end
    checks++; if (bus.resp_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", bus.resp_err); end
    checks++; if (bus.resp_data !== 64'd0) begin errors++; $display("FAIL tmo_data: got %h expected 0", bus.resp_data); end
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL tmo_resp_valid: got %b expected 1", bus.resp_valid); end
    bus.resp_ready = 1'b1;
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_div();
    // REM -20 % 6 = -2
    drive_req(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6);
    tick();
    checks++; if (bus.div_valid !== 1'b1) begin errors++; $display("FAIL rem_div_valid: got %b expected 1", bus.div_valid); end
    checks++; if (bus.div_signed !== 1'b1) begin errors++; $display("FAIL rem_div_signed: got %b expected 1", bus.div_signed); end
    checks++; if (bus.div_word !== 1'b0) begin errors++; $display("FAIL rem_div_word: got %b expected 0", bus.div_word); end
    bus.div_ok = 1'b1;
    bus.div_q  = 64'hFFFF_FFFF_FFFF_FFFD;
    bus.div_r  = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    bus.div_ok = 1'b0;
    #1;
    checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL rem_div_valid_drop: got %b expected 0", bus.div_valid); end
    checks++; if (bus.resp_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem_data: got %h expected fffffffffffffffe", bus.resp_data); end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    // DIVUW: quotient low word sign-extended
    drive_req(3'b101, 1'b1, 64'h0000_0001_2000_0000, 64'd2);
    tick();
    checks++; if (bus.div_signed !== 1'b0) begin errors++; $display("FAIL divuw_signed: got %b expected 0", bus.div_signed); end
    checks++; if (bus.div_word !== 1'b1) begin errors++; $display("FAIL divuw_word: got %b expected 1", bus.div_word); end
    bus.div_ok = 1'b1;
    bus.div_q  = 64'h0000_0000_9000_0000;
    bus.div_r  = 64'd1;
    tick();
    bus.div_ok = 1'b0;
    #1;
    checks++; if (bus.resp_data !== 64'hFFFF_FFFF_9000_0000) begin errors++; $display("FAIL divuw_data: got %h expected ffffffff90000000", bus.resp_data); end
    bus.resp_ready = 1'b1;
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_kill();
    // kill while idle: request ignored
    drive_req(3'b000, 1'b0, 64'd2, 64'd2);
    bus.kill = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL kill_idle_stall: got %b expected 0", bus.stall_o); end
    tick();
    checks++; if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL kill_idle_mul_valid: got %b expected 0", bus.mul_valid); end
    bus.kill = 1'b0;
    // kill in second wait cycle of DIV -> drain
    drive_req(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6);
    tick();
    tick();
    bus.kill      = 1'b1;
    bus.req_valid = 1'b0;
    tick();
    bus.kill = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL drain_stall: got %b expected 0", bus.stall_o); end
    checks++; if (bus.div_valid !== 1'b1) begin errors++; $display("FAIL drain_div_valid: got %b expected 1", bus.div_valid); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL drain_resp_valid: got %b expected 0", bus.resp_valid); end
    drive_req(3'b000, 1'b0, 64'd3, 64'd3);
    #1;
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL drain_new_req_stall: got %b expected 1", bus.stall_o); end
    bus.req_valid = 1'b0;
    tick();
    bus.div_ok = 1'b1;
    bus.div_q  = 64'hFFFF_FFFF_FFFF_FFFD;
    #1;
    checks++; if (bus.div_valid !== 1'b1) begin errors++; $display("FAIL drain_div_valid_ok: got %b expected 1", bus.div_valid); end
    tick();
    bus.div_ok = 1'b0;
    #1;
    checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL drain_exit_div_valid: got %b expected 0", bus.div_valid); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL drain_exit_resp: got %b expected 0", bus.resp_valid); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL drain_no_late_resp: got %b expected 0", bus.resp_valid); end
    // kill together with mul_ok: straight to idle, no response
    drive_req(3'b000, 1'b0, 64'd4, 64'd5);
    tick();
    bus.req_valid = 1'b0;
    bus.kill      = 1'b1;
    bus.mul_ok    = 1'b1;
    bus.mul_out   = 64'd20;
    tick();
    bus.kill   = 1'b0;
    bus.mul_ok = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL kill_ok_resp: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL kill_ok_mul_valid: got %b expected 0", bus.mul_valid); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL kill_ok_stall: got %b expected 0", bus.stall_o); end
  endtask

  task automatic test_async_reset();
    drive_req(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6);
    tick();
    checks++; if (bus.div_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_div_valid: got %b expected 1", bus.div_valid); end
    #2;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL areset_div_valid: got %b expected 0", bus.div_valid); end
    checks++; if (bus.mul_valid !== 1'b0) begin errors++; $display("FAIL areset_mul_valid: got %b expected 0", bus.mul_valid); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL areset_resp_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 64'd0) begin errors++; $display("FAIL areset_resp_data: got %h expected 0", bus.resp_data); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL areset_stall: got %b expected 0", bus.stall_o); end
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    clear_inputs();
    #2;
    test_reset();
    #10;
    reset = 1'b0;
    tick();
    test_mul();
    test_fastpath();
    test_unsupported();
    test_timeout();
    test_div();
    test_kill();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
